// File: rtl/axi4_m512_wr_arb_if.sv
// Bundle between the packet FIFOs, the write arbiter and the axi4_m512_mmu write master.
// master: arbiter side (drives pops, muxed head, grant id, counters).
// slave: environment side (FIFO heads, mmu pop, B-channel handshake).
interface axi4_m512_wr_arb_if #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2,
    parameter int WORD_W  = 540
);
    logic [NUM_SRC-1:0]        src_ef;
    logic [NUM_SRC-1:0]        src_sop;
    logic [NUM_SRC*WORD_W-1:0] src_rdata;
    logic [NUM_SRC-1:0]        src_rd;
    logic                      arb_ef;
    logic                      arb_sop;
    logic [WORD_W-1:0]         arb_rdata;
    logic                      arb_rd;
    logic [SRC_W-1:0]          arb_gnt_id;
    logic                      b_vld;
    logic [3:0]                outstd_cnt;
    logic                      sop_err;

    modport master (
        input  src_ef, src_sop, src_rdata, arb_rd, b_vld,
        output src_rd, arb_ef, arb_sop, arb_rdata, arb_gnt_id, outstd_cnt, sop_err
    );

    modport slave (
        output src_ef, src_sop, src_rdata, arb_rd, b_vld,
        input  src_rd, arb_ef, arb_sop, arb_rdata, arb_gnt_id, outstd_cnt, sop_err
    );
endinterface

// File: rtl/axi4_m512_wr_arb.sv
// Packet-granular arbiter muxing NUM_SRC packet FIFOs onto one mmu write master.
// Latency: request to arb_ef low 1 clkr; one IDLE cycle between packets.
// Backpressure: grant held for the whole packet; no new grant at MAX_OUTSTD in-flight packets.
// Option WR_ARB_STRICT_PRI_EN: source 0 has strict priority, others round-robin.
module axi4_m512_wr_arb #(
    parameter int NUM_SRC    = 4,
    parameter int SRC_W      = 2,
    parameter int EOP_POS    = 519,
    parameter int MAX_OUTSTD = 8
) (
    input  logic               clkr,
    input  logic               reset_clkr,
    axi4_m512_wr_arb_if.master bus
);
    localparam int WORD_W = 540;
`ifdef WR_ARB_STRICT_PRI_EN
    localparam logic [SRC_W-1:0] RR_RST = SRC_W'(1);
`else
    localparam logic [SRC_W-1:0] RR_RST = '0;
`endif

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

    state_t             r_state, w_state_nxt;
    logic [SRC_W-1:0]   r_gnt, w_gnt_nxt;
    logic [SRC_W-1:0]   r_rr_ptr, w_rr_nxt, w_rr_adv;
    logic [3:0]         r_outstd, w_outstd_nxt;
    logic               r_sop_err, w_sop_err_nxt;
    logic [SRC_W-1:0]   w_pick, w_idx;
    logic               w_any;
    logic [NUM_SRC-1:0] w_elig;
    logic               w_lock, w_eop_pop, w_rr_bad;
    logic [WORD_W-1:0]  w_head;

    assign w_elig    = ~bus.src_ef & bus.src_sop;
    assign w_lock    = (r_state == ST_LOCK);
    assign w_head    = bus.src_rdata[int'(r_gnt)*WORD_W +: WORD_W];
    assign w_eop_pop = w_lock & bus.arb_rd & w_head[EOP_POS];
    // A non-empty head at the pointer without SOP means a framing error upstream.
    assign w_rr_bad  = ~bus.src_ef[r_rr_ptr] & ~bus.src_sop[r_rr_ptr];

    assign bus.arb_rdata  = w_head;
    assign bus.arb_sop    = bus.src_sop[r_gnt] & w_lock;
    assign bus.arb_ef     = ~w_lock | bus.src_ef[r_gnt];
    assign bus.src_rd     = (bus.arb_rd & w_lock) ? (NUM_SRC'(1) << r_gnt) : '0;
    assign bus.arb_gnt_id = r_gnt;
    assign bus.outstd_cnt = r_outstd;
    assign bus.sop_err    = r_sop_err;

    // Pointer advance after a packet completes.
`ifdef WR_ARB_STRICT_PRI_EN
    assign w_rr_adv = (r_gnt == '0) ? r_rr_ptr :
                      (r_gnt == SRC_W'(NUM_SRC-1)) ? SRC_W'(1) : r_gnt + SRC_W'(1);
`else
    assign w_rr_adv = (r_gnt == SRC_W'(NUM_SRC-1)) ? '0 : r_gnt + SRC_W'(1);
`endif

    // Select the first eligible source searching from the round-robin pointer.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
`ifdef WR_ARB_STRICT_PRI_EN
        for (int k = NUM_SRC-2; k >= 0; k--) begin
            w_idx = SRC_W'(1 + ((int'(r_rr_ptr) - 1 + k) % (NUM_SRC-1)));
            if (w_elig[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
        if (w_elig[0]) begin
            w_any  = 1'b1;
            w_pick = '0;
        end
`else
        for (int k = NUM_SRC-1; k >= 0; k--) begin
            w_idx = SRC_W'((int'(r_rr_ptr) + k) % NUM_SRC);
            if (w_elig[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
`endif
    end

    // Next-state: grant FSM, pointer, in-flight counter and sticky error.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_rr_nxt      = r_rr_ptr;
        w_outstd_nxt  = r_outstd;
        w_sop_err_nxt = r_sop_err;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_bad) w_sop_err_nxt = 1'b1;
                if (w_any && (r_outstd < 4'(MAX_OUTSTD))) begin
                    w_state_nxt = ST_LOCK;
                    w_gnt_nxt   = w_pick;
                end
            end
            ST_LOCK: begin
                if (w_eop_pop) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = w_rr_adv;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_eop_pop && !bus.b_vld) begin
            w_outstd_nxt = r_outstd + 4'd1;
        end else if (!w_eop_pop && bus.b_vld) begin
            if (r_outstd == 4'd0) w_sop_err_nxt = 1'b1;
            else                  w_outstd_nxt  = r_outstd - 4'd1;
        end
    end

    // State registers; reset drops any grant immediately.
    always_ff @(posedge clkr or posedge reset_clkr) begin
        if (reset_clkr) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_rr_ptr  <= RR_RST;
            r_outstd  <= 4'd0;
            r_sop_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_outstd  <= w_outstd_nxt;
            r_sop_err <= w_sop_err_nxt;
        end
    end
endmodule

// File: tb/tb_axi4_m512_wr_arb.sv
// Directed bench for axi4_m512_wr_arb: inputs change on the falling edge,
// outputs are sampled 1 time unit after it, well away from the rising edge.
module tb_axi4_m512_wr_arb;
    logic clkr = 1'b0;
    logic reset_clkr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    axi4_m512_wr_arb_if #(.NUM_SRC(4), .SRC_W(2), .WORD_W(540)) bus ();

    axi4_m512_wr_arb #(.NUM_SRC(4), .SRC_W(2), .EOP_POS(519), .MAX_OUTSTD(8)) dut (
        .clkr       (clkr),
        .reset_clkr (reset_clkr),
        .bus        (bus)
    );

    always #5 clkr = ~clkr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Head word of source i: tag i in bits [7:0], eop at bit 519.
    task automatic set_src(input int i, input logic ef, input logic sop, input logic eop);
        bus.src_ef[i]              = ef;
        bus.src_sop[i]             = sop;
        bus.src_rdata[i*540 +: 8]  = 8'(i);
        bus.src_rdata[i*540 + 519] = eop;
    endtask

    task automatic do_reset();
        reset_clkr    = 1'b1;
        bus.src_ef    = '1;
        bus.src_sop   = '0;
        bus.src_rdata = '0;
        bus.arb_rd    = 1'b0;
        bus.b_vld     = 1'b0;
        @(negedge clkr);
        @(negedge clkr);
        reset_clkr = 1'b0;
    endtask

    task automatic test_reset();
        reset_clkr = 1'b1;
        bus.src_ef = '1; bus.src_sop = '0; bus.src_rdata = '0;
        bus.arb_rd = 1'b0; bus.b_vld = 1'b0;
        @(negedge clkr); #1;
        checks++; if (bus.arb_ef !== 1'b1) begin errors++; $display("FAIL rst_arb_ef: got %b need 1", bus.arb_ef); end
        checks++; if (bus.arb_sop !== 1'b0) begin errors++; $display("FAIL rst_arb_sop: got %b need 0", bus.arb_sop); end
        checks++; if (bus.src_rd !== 4'b0) begin errors++; $display("FAIL rst_src_rd: got %b need 0000", bus.src_rd); end
        checks++; if (bus.arb_gnt_id !== 2'd0) begin errors++; $display("FAIL rst_gnt: got %0d need 0", bus.arb_gnt_id); end
        checks++; if (bus.outstd_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d need 0", bus.outstd_cnt); end
        checks++; if (bus.sop_err !== 1'b0) begin errors++; $display("FAIL rst_sop_err: got %b need 0", bus.sop_err); end
        // arb_rd while not granted must not pop
        bus.arb_rd = 1'b1; #1;
        checks++; if (bus.src_rd !== 4'b0) begin errors++; $display("FAIL rst_rd_ignored: got %b need 0000", bus.src_rd); end
        bus.arb_rd = 1'b0;
    endtask

    task automatic test_single_pkt();
        do_reset();
        set_src(0, 1'b0, 1'b1, 1'b0); #1;
        checks++; if (bus.arb_ef !== 1'b1) begin errors++; $display("FAIL pkt_ef_before: got %b need 1", bus.arb_ef); end
        @(negedge clkr); #1;
        checks++; if (bus.arb_ef !== 1'b0) begin errors++; $display("FAIL pkt_ef_lock: got %b need 0", bus.arb_ef); end
        checks++; if (bus.arb_gnt_id !== 2'd0) begin errors++; $display("FAIL pkt_gnt: got %0d need 0", bus.arb_gnt_id); end
        checks++; if (bus.arb_sop !== 1'b1) begin errors++; $display("FAIL pkt_sop: got %b need 1", bus.arb_sop); end
        bus.arb_rd = 1'b1; #1;
        checks++; if (bus.src_rd !== 4'b0001) begin errors++; $display("FAIL pkt_rd1: got %b need 0001", bus.src_rd); end
        @(negedge clkr);
        set_src(0, 1'b0, 1'b0, 1'b1); #1;
        checks++; if (bus.src_rd !== 4'b0001) begin errors++; $display("FAIL pkt_rd2: got %b need 0001", bus.src_rd); end
        checks++; if (bus.arb_rdata[519] !== 1'b1) begin errors++; $display("FAIL pkt_eop: got %b need 1", bus.arb_rdata[519]); end
        @(negedge clkr);
        bus.arb_rd = 1'b0;
        set_src(0, 1'b1, 1'b0, 1'b0); #1;
        checks++; if (bus.arb_ef !== 1'b1) begin errors++; $display("FAIL pkt_idle_ef: got %b need 1", bus.arb_ef); end
        checks++; if (bus.outstd_cnt !== 4'd1) begin errors++; $display("FAIL pkt_cnt: got %0d need 1", bus.outstd_cnt); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt [5];
`ifdef WR_ARB_STRICT_PRI_EN
        exp_gnt = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_gnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clkr); #1;
            checks++; if (bus.arb_ef !== 1'b0) begin errors++; $display("FAIL rr_ef_lock[%0d]: got %b need 0", k, bus.arb_ef); end
            checks++; if (bus.arb_gnt_id !== exp_gnt[k]) begin errors++; $display("FAIL rr_gnt[%0d]: got %0d need %0d", k, bus.arb_gnt_id, exp_gnt[k]); end
            checks++; if (bus.arb_rdata[7:0] !== 8'(exp_gnt[k])) begin errors++; $display("FAIL rr_data[%0d]: got %0d need %0d", k, bus.arb_rdata[7:0], exp_gnt[k]); end
            bus.arb_rd = 1'b1;
            @(negedge clkr);
            bus.arb_rd = 1'b0; #1;
            checks++; if (bus.arb_ef !== 1'b1) begin errors++; $display("FAIL rr_gap[%0d]: got %b need 1", k, bus.arb_ef); end
        end
        checks++; if (bus.outstd_cnt !== 4'd5) begin errors++; $display("FAIL rr_cnt: got %0d need 5", bus.outstd_cnt); end
    endtask

    task automatic test_outstanding();
        do_reset();
        set_src(0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clkr); #1;
            checks++; if (bus.arb_ef !== 1'b0) begin errors++; $display("FAIL os_grant[%0d]: got ef %b need 0", k, bus.arb_ef); end
            bus.arb_rd = 1'b1;
            @(negedge clkr);
            bus.arb_rd = 1'b0;
        end
        #1;
        checks++; if (bus.outstd_cnt !== 4'd8) begin errors++; $display("FAIL os_cnt_full: got %0d need 8", bus.outstd_cnt); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clkr); #1;
            checks++; if (bus.arb_ef !== 1'b1) begin errors++; $display("FAIL os_blocked[%0d]: got ef %b need 1", k, bus.arb_ef); end
        end
        bus.b_vld = 1'b1;
        @(negedge clkr);
        bus.b_vld = 1'b0; #1;
        checks++; if (bus.outstd_cnt !== 4'd7) begin errors++; $display("FAIL os_cnt_dec: got %0d need 7", bus.outstd_cnt); end
        checks++; if (bus.arb_ef !== 1'b1) begin errors++; $display("FAIL os_still_idle: got ef %b need 1", bus.arb_ef); end
        @(negedge clkr); #1;
        checks++; if (bus.arb_ef !== 1'b0) begin errors++; $display("FAIL os_ninth: got ef %b need 0", bus.arb_ef); end
        bus.arb_rd = 1'b1;
        @(negedge clkr);
        bus.arb_rd = 1'b0;
        set_src(0, 1'b1, 1'b0, 1'b0); #1;
        checks++; if (bus.outstd_cnt !== 4'd8) begin errors++; $display("FAIL os_cnt_refill: got %0d need 8", bus.outstd_cnt); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_src(0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clkr);
            bus.arb_rd = 1'b1;
            @(negedge clkr);
            bus.arb_rd = 1'b0;
        end
        @(negedge clkr); #1;
        checks++; if (bus.outstd_cnt !== 4'd3) begin errors++; $display("FAIL sc_cnt_pre: got %0d need 3", bus.outstd_cnt); end
        checks++; if (bus.arb_ef !== 1'b0) begin errors++; $display("FAIL sc_lock: got ef %b need 0", bus.arb_ef); end
        bus.arb_rd = 1'b1;
        bus.b_vld  = 1'b1;
        @(negedge clkr);
        bus.arb_rd = 1'b0;
        bus.b_vld  = 1'b0;
        set_src(0, 1'b1, 1'b0, 1'b0); #1;
        checks++; if (bus.outstd_cnt !== 4'd3) begin errors++; $display("FAIL sc_cnt_same: got %0d need 3", bus.outstd_cnt); end
        bus.b_vld = 1'b1;
        @(negedge clkr);
        bus.b_vld = 1'b0; #1;
        checks++; if (bus.outstd_cnt !== 4'd2) begin errors++; $display("FAIL sc_cnt_b: got %0d need 2", bus.outstd_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        set_src(1, 1'b0, 1'b1, 1'b0);
        set_src(2, 1'b0, 1'b1, 1'b1);
        @(negedge clkr); #1;
        checks++; if (bus.arb_gnt_id !== 2'd1) begin errors++; $display("FAIL st_gnt: got %0d need 1", bus.arb_gnt_id); end
        checks++; if (bus.arb_rdata[7:0] !== 8'd1) begin errors++; $display("FAIL st_data: got %0d need 1", bus.arb_rdata[7:0]); end
        bus.arb_rd = 1'b1;
        @(negedge clkr);
        bus.arb_rd = 1'b0;
        set_src(1, 1'b1, 1'b0, 1'b0); #1;
        checks++; if (bus.arb_ef !== 1'b1) begin errors++; $display("FAIL st_ef_empty: got %b need 1", bus.arb_ef); end
        repeat (2) @(negedge clkr);
        #1;
        checks++; if (bus.arb_gnt_id !== 2'd1) begin errors++; $display("FAIL st_gnt_hold: got %0d need 1", bus.arb_gnt_id); end
        checks++; if (bus.arb_ef !== 1'b1) begin errors++; $display("FAIL st_ef_hold: got %b need 1", bus.arb_ef); end
        set_src(1, 1'b0, 1'b0, 1'b1);
        bus.arb_rd = 1'b1; #1;
        checks++; if (bus.src_rd !== 4'b0010) begin errors++; $display("FAIL st_rd: got %b need 0010", bus.src_rd); end
        @(negedge clkr);
        bus.arb_rd = 1'b0;
        set_src(1, 1'b1, 1'b0, 1'b0); #1;
        checks++; if (bus.arb_ef !== 1'b1) begin errors++; $display("FAIL st_idle: got %b need 1", bus.arb_ef); end
        @(negedge clkr); #1;
        checks++; if (bus.arb_gnt_id !== 2'd2) begin errors++; $display("FAIL st_next_gnt: got %0d need 2", bus.arb_gnt_id); end
        checks++; if (bus.arb_ef !== 1'b0) begin errors++; $display("FAIL st_next_ef: got %b need 0", bus.arb_ef); end
    endtask

    task automatic test_b_underflow();
        do_reset();
        bus.b_vld = 1'b1;
        @(negedge clkr);
        bus.b_vld = 1'b0; #1;
        checks++; if (bus.outstd_cnt !== 4'd0) begin errors++; $display("FAIL bu_cnt: got %0d need 0", bus.outstd_cnt); end
        checks++; if (bus.sop_err !== 1'b1) begin errors++; $display("FAIL bu_err: got %b need 1", bus.sop_err); end
        repeat (2) @(negedge clkr);
        #1;
        checks++; if (bus.sop_err !== 1'b1) begin errors++; $display("FAIL bu_sticky: got %b need 1", bus.sop_err); end
        do_reset(); #1;
        checks++; if (bus.sop_err !== 1'b0) begin errors++; $display("FAIL bu_clear: got %b need 0", bus.sop_err); end
    endtask

    task automatic test_no_sop_skip();
        logic exp_err;
`ifdef WR_ARB_STRICT_PRI_EN
        exp_err = 1'b0;
`else
        exp_err = 1'b1;
`endif
        do_reset();
        set_src(0, 1'b0, 1'b0, 1'b0);
        set_src(1, 1'b0, 1'b1, 1'b1);
        @(negedge clkr); #1;
        checks++; if (bus.arb_gnt_id !== 2'd1) begin errors++; $display("FAIL ns_gnt: got %0d need 1", bus.arb_gnt_id); end
        checks++; if (bus.arb_ef !== 1'b0) begin errors++; $display("FAIL ns_ef: got %b need 0", bus.arb_ef); end
        checks++; if (bus.sop_err !== exp_err) begin errors++; $display("FAIL ns_err: got %b need %b", bus.sop_err, exp_err); end
    endtask

    initial begin
        test_reset();
        test_single_pkt();
        test_round_robin();
        test_outstanding();
        test_same_cycle();
        test_stall();
        test_b_underflow();
        test_no_sop_skip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
